conv1_relu_pool: RTL and testbench

Post-processing stage directly downstream of the first convolution layer. Consumes the layer's 32-bit per-pixel result stream in raster order, applies ReLU, 2x2 stride-2 max pooling and a right-shift requantization with saturation, and emits a 16-bit pooled feature stream sized for the next layer's 16-bit input port. It has no backpressure: it accepts one beat per cycle at any rate the conv layer produces.

---
 rtl/conv1_relu_pool.sv | 137 +++++++++++++
 tb/tb_conv1_relu_pool.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_relu_pool.sv
// ReLU + 2x2 stride-2 max pool + shift/saturate requantization for a raster
// pixel stream; one beat per cycle, registered outputs, no backpressure.
module conv1_relu_pool #(
  parameter int unsigned IMG_W = 26,
  parameter int unsigned IMG_H = 26,
  parameter int unsigned SHIFT = 8
) (
  input  logic        h_clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_finish,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_finish,
  output logic        invalid
);

  localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam bit          W_ODD  = (IMG_W % 2) == 1;
  localparam bit          H_ODD  = (IMG_H % 2) == 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Handshake: a beat transfers on every rising edge where in_valid is high;
  // there is no ready, the stage always accepts.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0]   h_q, h_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_finish_q, out_finish_d;
  logic          invalid_q, invalid_d;

  logic [31:0]   lbuf [HALF_W];

  logic [31:0]   relu;
  logic [31:0]   hmax;
  logic [31:0]   lb_rd;
  logic [31:0]   win_max;
  logic [31:0]   q;
  logic [15:0]   q_sat;
  logic [AW-1:0] lb_idx;
  logic          at_last;
  logic          bad_fin;
  logic          row_live;
  logic          col_live;
  logic          lb_we;
  logic          win_close;

  always_comb begin
    relu      = in_data[31] ? 32'd0 : in_data;
    hmax      = (h_q > relu) ? h_q : relu;
    lb_idx    = AW'(col_q >> 1);
    lb_rd     = lbuf[lb_idx];
    win_max   = (lb_rd > hmax) ? lb_rd : hmax;
    q         = win_max >> SHIFT;
    q_sat     = (q > 32'd32767) ? 16'h7FFF : q[15:0];
    at_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // A finish marker anywhere but on the accepted last beat abandons the frame.
    bad_fin   = in_finish && !(in_valid && at_last);
    col_live  = !(W_ODD && (col_q == COL_LAST));
    row_live  = !(H_ODD && (row_q == ROW_LAST));
    lb_we     = in_valid && !bad_fin && col_q[0] && !row_q[0] && row_live;
    win_close = in_valid && !bad_fin && col_q[0] && row_q[0];
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_d          = h_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_finish_d = 1'b0;
    invalid_d    = bad_fin;
    if (bad_fin) begin
      col_d = '0;
      row_d = '0;
      h_d   = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = at_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0] && col_live && row_live) begin
        h_d = relu;
      end
      if (win_close) begin
        out_valid_d = 1'b1;
        out_data_d  = q_sat;
      end
      if (at_last) begin
        out_finish_d = 1'b1;
        invalid_d    = !in_finish;
      end
    end
  end

  always_ff @(posedge h_clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      h_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_finish_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_q          <= h_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_finish_q <= out_finish_d;
      invalid_q    <= invalid_d;
    end
  end

  // Line buffer keeps no reset: every entry is written on an even row before
  // the odd row reads it.
  always_ff @(posedge h_clk) begin
    if (lb_we) begin
      lbuf[lb_idx] <= hmax;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_finish = out_finish_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_conv1_relu_pool.sv
// Self-checking bench for conv1_relu_pool: three parameterizations share one
// input stream; only the selected instance is scored.
module tb_conv1_relu_pool;

  logic        h_clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_finish;

  logic [15:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_fin, b_fin, c_fin;
  logic        a_inv, b_inv, c_inv;

  conv1_relu_pool #(.IMG_W(4), .IMG_H(4), .SHIFT(0)) u_a (
    .h_clk(h_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_finish(in_finish), .out_data(a_data), .out_valid(a_valid),
    .out_finish(a_fin), .invalid(a_inv));

  conv1_relu_pool #(.IMG_W(4), .IMG_H(4), .SHIFT(8)) u_b (
    .h_clk(h_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_finish(in_finish), .out_data(b_data), .out_valid(b_valid),
    .out_finish(b_fin), .invalid(b_inv));

  conv1_relu_pool #(.IMG_W(5), .IMG_H(5), .SHIFT(0)) u_c (
    .h_clk(h_clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_finish(in_finish), .out_data(c_data), .out_valid(c_valid),
    .out_finish(c_fin), .invalid(c_inv));

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;
  always @(posedge h_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_tag_q[$];
  int          fin_q[$];
  int          inv_q[$];
  logic [15:0] got_q[16][$];
  logic [31:0] px[32];

  logic [15:0] mo_d;
  logic        mo_v, mo_f, mo_i;
  assign mo_d = (sel == 0) ? a_data  : (sel == 1) ? b_data  : c_data;
  assign mo_v = (sel == 0) ? a_valid : (sel == 1) ? b_valid : c_valid;
  assign mo_f = (sel == 0) ? a_fin   : (sel == 1) ? b_fin   : c_fin;
  assign mo_i = (sel == 0) ? a_inv   : (sel == 1) ? b_inv   : c_inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int at);
    n_vec++;
    n_err++;
    $display("FAIL %s: event expected at cycle %0d, seen at cycle %0d", nm, at, cyc);
  endtask

  always @(negedge h_clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      miss("out_valid_missing", exp_cyc_q[0]);
      void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_tag_q.pop_front());
    end
    while (fin_q.size() > 0 && fin_q[0] < cyc) begin
      miss("out_finish_missing", fin_q[0]);
      void'(fin_q.pop_front());
    end
    while (inv_q.size() > 0 && inv_q[0] < cyc) begin
      miss("invalid_missing", inv_q[0]);
      void'(inv_q.pop_front());
    end
    if (mo_v) begin
      if (exp_q.size() == 0) miss("out_valid_unexpected", -1);
      else begin
        chk("out_data", {16'd0, mo_d}, {16'd0, exp_q[0]});
        chk("out_valid_cycle", cyc, exp_cyc_q[0]);
        got_q[exp_tag_q[0]].push_back(mo_d);
        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_tag_q.pop_front());
      end
    end
    if (mo_f) begin
      if (fin_q.size() == 0) miss("out_finish_unexpected", -1);
      else begin
        chk("out_finish_cycle", cyc, fin_q[0]);
        void'(fin_q.pop_front());
      end
    end
    if (mo_i) begin
      if (inv_q.size() == 0) miss("invalid_unexpected", -1);
      else begin
        chk("invalid_cycle", cyc, inv_q[0]);
        void'(inv_q.pop_front());
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [31:0] rl(input logic [31:0] v);
    return v[31] ? 32'd0 : v;
  endfunction

  function automatic logic [31:0] mx(input logic [31:0] x, input logic [31:0] y);
    return (x > y) ? x : y;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge h_clk); #1;
    in_valid  = 1'b0;
    in_finish = 1'b0;
    in_data   = $urandom();
  endtask

  task automatic apply_reset();
    @(posedge h_clk); #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_finish = 1'b1;
    repeat (2) @(posedge h_clk);
    #1;
    reset     = 1'b1;
    in_finish = 1'b0;
  endtask

  task automatic run_frame(input int tag, input int sel_i, input int pat, input int gap_max,
                           input int abort_at, input bit drop_fin, input int nb);
    int w, h, sh, row, col, cap;
    logic [31:0] m, q;
    w  = (sel_i == 2) ? 5 : 4;
    h  = w;
    sh = (sel_i == 1) ? 8 : 0;
    for (int k = 0; k < w * h; k++) begin
      case (pat)
        0: px[k] = k;
        1: px[k] = (k % 3 == 0) ? 32'hFFFF_FFFF : (k % 3 == 1) ? -32'sd100 : 32'h8000_0000;
        2: px[k] = (k == 0) ? 32'h7FFF_FFFF : (k == 6) ? 32'h0000_1234 : k;
        default: px[k] = $urandom();
      endcase
    end
    for (int k = 0; k < nb; k++) begin
      if (gap_max > 0 && k > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
      @(posedge h_clk); #1;
      in_valid  = 1'b1;
      in_data   = px[k];
      in_finish = (k == abort_at) || (k == w * h - 1 && !drop_fin);
      cap = cyc + 1;
      row = k / w;
      col = k % w;
      if (k == abort_at) begin
        inv_q.push_back(cap);
        break;
      end
      if (row % 2 == 1 && col % 2 == 1 && col < (w / 2) * 2 && row < (h / 2) * 2) begin
        m = mx(mx(rl(px[k]), rl(px[k-1])), mx(rl(px[k-w]), rl(px[k-w-1])));
        q = m >> sh;
        exp_q.push_back((q > 32'd32767) ? 16'h7FFF : q[15:0]);
        exp_cyc_q.push_back(cap);
        exp_tag_q.push_back(tag);
      end
      if (k == w * h - 1) begin
        fin_q.push_back(cap);
        if (drop_fin) inv_q.push_back(cap);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              sel;
    bit              do_reset;
    int              pat;
    int              gap_max;
    int              abort_at;
    bit              drop_fin;
    int              n_exp;
    logic [3:0][15:0] e;
  } vec_t;

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1, 0, 0, -1, 0,  4, {16'd15, 16'd13, 16'd7, 16'd5}};
    vt[1] = '{0, 0, 1, 0, -1, 0,  4, {16'd0, 16'd0, 16'd0, 16'd0}};
    vt[2] = '{1, 0, 2, 0, -1, 0,  4, {16'd0, 16'd0, 16'h0012, 16'h7FFF}};
    vt[3] = '{0, 0, 0, 3, -1, 0,  4, {16'd15, 16'd13, 16'd7, 16'd5}};
    vt[4] = '{0, 0, 0, 0,  9, 0,  2, {16'd0, 16'd0, 16'd7, 16'd5}};
    vt[5] = '{0, 0, 0, 0, -1, 0,  4, {16'd15, 16'd13, 16'd7, 16'd5}};
    vt[6] = '{0, 0, 0, 0, -1, 1,  4, {16'd15, 16'd13, 16'd7, 16'd5}};
    vt[7] = '{0, 0, 3, 2, -1, 0, -1, {16'd0, 16'd0, 16'd0, 16'd0}};
    vt[8] = '{2, 1, 0, 0, -1, 0,  4, {16'd18, 16'd16, 16'd8, 16'd6}};
    vt[9] = '{2, 0, 3, 1, -1, 0, -1, {16'd0, 16'd0, 16'd0, 16'd0}};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_finish = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge h_clk);
    #1;
    chk("rst_a_data", {16'd0, a_data}, 32'd0);
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_a_finish", {31'd0, a_fin}, 32'd0);
    chk("rst_a_invalid", {31'd0, a_inv}, 32'd0);
    chk("rst_c_data", {16'd0, c_data}, 32'd0);
    chk("rst_c_valid", {31'd0, c_valid}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].sel != sel || vt[i].do_reset) begin
        repeat (3) idle_cycle();
        if (vt[i].do_reset) apply_reset();
        sel = vt[i].sel;
      end
      run_frame(i, vt[i].sel, vt[i].pat, vt[i].gap_max, vt[i].abort_at, vt[i].drop_fin,
                (vt[i].sel == 2) ? 25 : 16);
    end

    // Reset mid-frame on the 4x4 instance, then a clean ramp frame.
    repeat (3) idle_cycle();
    sel = 0;
    apply_reset();
    run_frame(10, 0, 0, 0, -1, 0, 7);
    repeat (2) idle_cycle();
    @(posedge h_clk); #1;
    reset     = 1'b0;
    in_finish = 1'b1;
    #1;
    chk("midrst_data", {16'd0, a_data}, 32'd0);
    chk("midrst_valid", {31'd0, a_valid}, 32'd0);
    repeat (2) @(posedge h_clk);
    #1;
    reset     = 1'b1;
    in_finish = 1'b0;
    run_frame(11, 0, 0, 0, -1, 0, 16);
    repeat (6) idle_cycle();

    for (int i = 0; i < 10; i++) begin
      if (vt[i].n_exp >= 0) begin
        chk($sformatf("vec%0d_count", i), got_q[i].size(), vt[i].n_exp);
        for (int j = 0; j < vt[i].n_exp; j++)
          if (j < got_q[i].size())
            chk($sformatf("vec%0d_out%0d", i, j), {16'd0, got_q[i][j]}, {16'd0, vt[i].e[j]});
      end
    end
    chk("partial_count", got_q[10].size(), 1);
    if (got_q[10].size() > 0) chk("partial_out0", {16'd0, got_q[10][0]}, 32'd5);
    chk("post_rst_count", got_q[11].size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < got_q[11].size())
        chk($sformatf("post_rst_out%0d", j), {16'd0, got_q[11][j]}, 32'(vt[0].e[j]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
